// File: rtl/strobe_pkg.sv
// Shared definitions for the strobe schedulers.
//   state_e       : transaction sequencer states (IDLE, SETUP, STROBE, HOLD)
//   STROBE_ACTIVE : level of the active-low strobe when asserted
//   STROBE_IDLE   : level of the active-low strobe when released
package strobe_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_e;

  localparam logic STROBE_ACTIVE = 1'b0;
  localparam logic STROBE_IDLE   = 1'b1;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// Ports:
//   req        in  NREQ  request vector
//   mask       in  NREQ  eligibility mask, ANDed with req
//   ptr        in  IW    search start position (searches upward, wraps)
//   found      out 1     some masked request is set
//   winner_idx out IW    index of the first masked request from ptr, 0 if none
module rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] mask,
  input  logic [IW-1:0]   ptr,
  output logic            found,
  output logic [IW-1:0]   winner_idx
);

  logic [NREQ-1:0] cand;
  logic [IW-1:0]   idx;
  int unsigned     pos;

  always_comb begin
    cand       = req & mask;
    found      = 1'b0;
    winner_idx = '0;
    idx        = '0;
    pos        = 0;
    // Visit positions ptr, ptr+1, ... modulo NREQ; first hit wins.
    for (int unsigned k = 0; k < NREQ; k++) begin
      pos = 32'(ptr) + k;
      if (pos >= NREQ) pos = pos - NREQ;
      idx = IW'(pos);
      if (!found && cand[idx]) begin
        found      = 1'b1;
        winner_idx = idx;
      end
    end
  end

endmodule

// File: rtl/write_strobe_scheduler.sv
// Shares one active-low write strobe between NREQ requesters. A round-robin
// winner gets a one-hot data-steering grant, then the block runs
// SETUP (1 cycle) -> STROBE (PULSE_CYCLES, strobe low) -> HOLD (HOLD_CYCLES),
// pulsing ack to the grantee in the last HOLD cycle.
// Ports:
//   clk       in  1     clock, rising edge
//   _reset    in  1     synchronous active-low reset
//   enable    in  1     allows new transactions to start
//   req       in  NREQ  level requests, held until ack
//   grant     out NREQ  one-hot steering select, zero when idle
//   grant_idx out IW    binary grantee index, zero when idle
//   _strobe   out 1     active-low shared write strobe
//   ack       out NREQ  one-cycle completion pulse
//   busy      out 1     high outside IDLE
module write_strobe_scheduler
  import strobe_pkg::*;
#(
  parameter int unsigned NREQ         = 4,
  parameter int unsigned PULSE_CYCLES = 2,
  parameter int unsigned HOLD_CYCLES  = 1,
  localparam int unsigned IW          = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            _reset,
  input  logic            enable,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   grant_idx,
  output logic            _strobe,
  output logic [NREQ-1:0] ack,
  output logic            busy
);

  state_e          state_q;
  logic [3:0]      cnt_q;
  logic [IW-1:0]   ptr_q;
  logic [NREQ-1:0] grant_q;
  logic [IW-1:0]   grant_idx_q;
  logic            strobe_q;
  logic [NREQ-1:0] ack_q;
  logic            busy_q;

  logic [NREQ-1:0] mask;
  logic            found;
  logic [IW-1:0]   win;
  logic [IW-1:0]   ptr_d;
  logic [NREQ-1:0] win_onehot;

  // Leaving HOLD, the finishing grantee is masked out so it cannot win twice
  // in a row; in IDLE everyone is eligible.
  always_comb begin
    mask       = (state_q == HOLD) ? ~grant_q : '1;
    ptr_d      = (win == IW'(NREQ - 1)) ? '0 : win + 1'b1;
    win_onehot = NREQ'(1) << win;
  end

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req        (req),
    .mask       (mask),
    .ptr        (ptr_q),
    .found      (found),
    .winner_idx (win)
  );

  always_ff @(posedge clk) begin
    if (!_reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ptr_q       <= '0;
      grant_q     <= '0;
      grant_idx_q <= '0;
      strobe_q    <= STROBE_IDLE;
      ack_q       <= '0;
      busy_q      <= 1'b0;
    end else begin
      ack_q <= '0;
      unique case (state_q)
        IDLE: begin
          if (enable && found) begin
            state_q     <= SETUP;
            grant_q     <= win_onehot;
            grant_idx_q <= win;
            ptr_q       <= ptr_d;
            busy_q      <= 1'b1;
          end
        end
        SETUP: begin
          state_q  <= STROBE;
          strobe_q <= STROBE_ACTIVE;
          cnt_q    <= 4'(PULSE_CYCLES - 1);
        end
        STROBE: begin
          if (cnt_q == 4'd0) begin
            state_q  <= HOLD;
            strobe_q <= STROBE_IDLE;
            cnt_q    <= 4'(HOLD_CYCLES - 1);
            // ack is registered, so it is launched on entry to the last HOLD cycle.
            if (HOLD_CYCLES == 1) ack_q <= grant_q;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        HOLD: begin
          if (cnt_q == 4'd0) begin
            if (enable && found) begin
              state_q     <= SETUP;
              grant_q     <= win_onehot;
              grant_idx_q <= win;
              ptr_q       <= ptr_d;
            end else begin
              state_q     <= IDLE;
              grant_q     <= '0;
              grant_idx_q <= '0;
              busy_q      <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == 4'd1) ack_q <= grant_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant     = grant_q;
  assign grant_idx = grant_idx_q;
  assign _strobe   = strobe_q;
  assign ack       = ack_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_write_strobe_scheduler.sv
// Directed bench for write_strobe_scheduler: one default instance plus one
// with PULSE_CYCLES=4 for the reset-abort scenario.
module tb_write_strobe_scheduler;

  logic       clk;
  logic       rst_n, en;
  logic [3:0] req;
  logic [3:0] grant, ack;
  logic [1:0] gidx;
  logic       strobe_n, busy;

  logic       rst4_n, en4;
  logic [3:0] req4;
  logic [3:0] grant4, ack4;
  logic [1:0] gidx4;
  logic       strobe4_n, busy4;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  write_strobe_scheduler dut (
    .clk       (clk),
    ._reset    (rst_n),
    .enable    (en),
    .req       (req),
    .grant     (grant),
    .grant_idx (gidx),
    ._strobe   (strobe_n),
    .ack       (ack),
    .busy      (busy)
  );

  write_strobe_scheduler #(
    .NREQ         (4),
    .PULSE_CYCLES (4),
    .HOLD_CYCLES  (1)
  ) dut4 (
    .clk       (clk),
    ._reset    (rst4_n),
    .enable    (en4),
    .req       (req4),
    .grant     (grant4),
    .grant_idx (gidx4),
    ._strobe   (strobe4_n),
    .ack       (ack4),
    .busy      (busy4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int unsigned pulses;
    logic        prev_strobe;
    logic [3:0]  exp_ack;

    rst_n = 1'b0; en = 1'b1; req = 4'b1111;
    rst4_n = 1'b0; en4 = 1'b1; req4 = 4'b0000;

    // Reset held with all requests asserted.
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("rst_strobe", 32'(strobe_n), 32'd1);
      check_eq("rst_grant",  32'(grant),    32'd0);
      check_eq("rst_busy",   32'(busy),     32'd0);
    end
    rst_n = 1'b1;
    tick();
    check_eq("rel_grant", 32'(grant), 32'b0001);
    check_eq("rel_busy",  32'(busy),  32'd1);
    req = 4'b0000;
    tick(); tick(); tick();
    check_eq("rel_ack", 32'(ack), 32'b0001);
    tick();
    check_eq("rel_idle_busy", 32'(busy), 32'd0);

    // Single request on requester 2.
    req = 4'b0100;
    for (int c = 0; c < 4; c++) begin
      tick();
      check_eq("single_gidx",   32'(gidx),     32'd2);
      check_eq("single_strobe", 32'(strobe_n), (c == 1 || c == 2) ? 32'd0 : 32'd1);
      check_eq("single_ack",    32'(ack),      (c == 3) ? 32'b0100 : 32'd0);
    end
    req = 4'b0000;
    tick();
    check_eq("single_idle_busy",  32'(busy),  32'd0);
    check_eq("single_idle_grant", 32'(grant), 32'd0);
    check_eq("single_idle_gidx",  32'(gidx),  32'd0);

    // All requesting after a fresh reset: order 0,1,2,3 back to back.
    rst_n = 1'b0; req = 4'b0000;
    tick();
    rst_n = 1'b1; req = 4'b1111;
    pulses = 0;
    prev_strobe = 1'b1;
    for (int c = 0; c < 16; c++) begin
      tick();
      check_eq("all_gidx", 32'(gidx), 32'(c / 4));
      check_eq("all_busy", 32'(busy), 32'd1);
      exp_ack = ((c % 4) == 3) ? (4'b0001 << (c / 4)) : 4'b0000;
      check_eq("all_ack", 32'(ack), 32'(exp_ack));
      if (prev_strobe && !strobe_n) pulses++;
      prev_strobe = strobe_n;
      req = req & ~exp_ack;
    end
    check_eq("all_pulses", pulses, 32'd4);
    tick();
    check_eq("all_idle_busy", 32'(busy), 32'd0);

    // Fairness: req0 permanently high, req3 raised once.
    req = 4'b0001;
    for (int c = 0; c < 9; c++) begin
      tick();
      if (c == 1) req = 4'b1001;
      if (c == 0) check_eq("fair_first", 32'(gidx), 32'd0);
      if (c == 3) check_eq("fair_ack0",  32'(ack),  32'b0001);
      if (c == 4) check_eq("fair_req3",  32'(gidx), 32'd3);
      if (c == 4) check_eq("fair_nogap", 32'(busy), 32'd1);
      if (c == 7) begin
        check_eq("fair_ack3", 32'(ack), 32'b1000);
        req = 4'b0001;
      end
      if (c == 8) begin
        check_eq("fair_back0", 32'(gidx), 32'd0);
        req = 4'b0000;
      end
    end
    for (int c = 0; c < 4; c++) tick();
    check_eq("fair_idle_busy", 32'(busy), 32'd0);

    // enable dropped mid-STROBE.
    req = 4'b0010;
    tick();
    check_eq("en_grant", 32'(grant), 32'b0010);
    tick();
    en = 1'b0;
    check_eq("en_strobe1", 32'(strobe_n), 32'd0);
    tick();
    check_eq("en_strobe2", 32'(strobe_n), 32'd0);
    tick();
    check_eq("en_ack", 32'(ack), 32'b0010);
    req = 4'b0100;
    tick();
    check_eq("en_idle_busy",  32'(busy),  32'd0);
    check_eq("en_idle_grant", 32'(grant), 32'd0);
    tick(); tick();
    check_eq("en_still_idle", 32'(busy), 32'd0);
    en = 1'b1;
    tick();
    check_eq("en_resume", 32'(grant), 32'b0100);
    req = 4'b0000;
    for (int c = 0; c < 4; c++) tick();
    check_eq("en_final_busy", 32'(busy), 32'd0);

    // Reset during STROBE on the PULSE_CYCLES=4 instance.
    rst4_n = 1'b1; req4 = 4'b0010;
    tick();
    check_eq("r4_grant", 32'(grant4), 32'b0010);
    tick(); tick();
    check_eq("r4_strobe_low", 32'(strobe4_n), 32'd0);
    rst4_n = 1'b0;
    tick();
    check_eq("r4_strobe", 32'(strobe4_n), 32'd1);
    check_eq("r4_grant0", 32'(grant4),    32'd0);
    check_eq("r4_busy",   32'(busy4),     32'd0);
    check_eq("r4_ack",    32'(ack4),      32'd0);
    tick();
    check_eq("r4_ack2",   32'(ack4),      32'd0);
    rst4_n = 1'b1; req4 = 4'b1111;
    tick();
    check_eq("r4_ptr0", 32'(grant4), 32'b0001);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
